// File: rtl/input_port_arbiter.sv
// -----------------------------------------------------------------------------
// input_port_arbiter
//
// Round-robin arbiter and sequencer that shares one input port between
// NUM_REQ packet sources. When idle it picks the first requesting source at or
// after the round-robin pointer, latches that source's payload into the
// arbiter-side output registers, and pulses arbiter_gnt/req_ack for one cycle.
// It then waits for the port to report encapsulation (a rising edge of
// ready_encap_dfx) and for the port's output FIFO to drain (empty) before it
// arbitrates again. A watchdog aborts a stuck transaction after TIMEOUT cycles.
//
// Ports:
//   clk                   clock, rising edge
//   rst                   asynchronous active-high reset
//   req                   per-requester request level (held until req_ack)
//   req_data/dst/hdr      flattened payloads, requester i at [i*W +: W]
//   req_ack               one-hot, one-cycle acknowledge to the winner
//   arbiter_gnt           one-cycle load strobe to the input port
//   data_arbiter_send     registered payload of the winner
//   dst_addr_arbiter_send registered destination of the winner
//   header_pkt_send       registered header of the winner
//   ready_encap_dfx       input port: encapsulation complete (edge-detected)
//   empty                 input port output FIFO empty
//   grant_id              index of the current/last granted requester
//   busy                  high whenever a transaction is in flight
//   timeout_err           sticky watchdog abort flag, cleared only by rst
// -----------------------------------------------------------------------------
module input_port_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 1024,
  parameter int ADDR_W  = 10,
  parameter int HDR_W   = 9,
  parameter int TIMEOUT = 1023,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
  input  logic [NUM_REQ*HDR_W-1:0]  req_hdr,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      arbiter_gnt,
  output logic [DATA_W-1:0]         data_arbiter_send,
  output logic [ADDR_W-1:0]         dst_addr_arbiter_send,
  output logic [HDR_W-1:0]          header_pkt_send,
  input  logic                      ready_encap_dfx,
  input  logic                      empty,
  output logic [ID_W-1:0]           grant_id,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT    = 2'd1,
    WAIT_RDY = 2'd2,
    DRAIN    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  sel;
  logic [ID_W-1:0]  idx;
  logic             sel_vld;
  logic             rdy_q;
  logic             rdy_edge;
  logic             edge_seen;
  logic [CNT_W-1:0] tmo_cnt;
  logic             tmo_hit;
  logic             in_wait;

  assign rdy_edge = ready_encap_dfx & ~rdy_q;
  assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT));
  assign in_wait  = (state == WAIT_RDY) || (state == DRAIN);

  // Round-robin search: first set req bit starting at ptr, wrapping around.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!sel_vld && req[idx]) begin
        sel     = idx;
        sel_vld = 1'b1;
      end
    end
  end

  // Next-state logic. The watchdog wins over any normal exit in the same cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (sel_vld) state_nxt = GRANT;
      GRANT:    state_nxt = WAIT_RDY;
      WAIT_RDY: begin
        if (tmo_hit)                     state_nxt = IDLE;
        else if (rdy_edge || edge_seen)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tmo_hit || empty) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      ptr                   <= '0;
      rdy_q                 <= 1'b0;
      edge_seen             <= 1'b0;
      tmo_cnt               <= '0;
      timeout_err           <= 1'b0;
      grant_id              <= '0;
      data_arbiter_send     <= '0;
      dst_addr_arbiter_send <= '0;
      header_pkt_send       <= '0;
    end else begin
      state <= state_nxt;
      rdy_q <= ready_encap_dfx;
      // An encapsulation edge that arrives while still in GRANT is carried
      // into the first WAIT_RDY cycle so it is not lost.
      edge_seen <= (state == GRANT) && rdy_edge;

      if (state == GRANT)
        tmo_cnt <= '0;
      else if (in_wait)
        tmo_cnt <= tmo_cnt + CNT_W'(1);

      if (in_wait && tmo_hit)
        timeout_err <= 1'b1;

      // Payload is captured only on a new grant, so it stays stable through
      // the transaction and keeps its last value while idle.
      if (state == IDLE && sel_vld) begin
        ptr                   <= ID_W'((int'(sel) + 1) % NUM_REQ);
        grant_id              <= sel;
        data_arbiter_send     <= req_data[int'(sel)*DATA_W +: DATA_W];
        dst_addr_arbiter_send <= req_dst[int'(sel)*ADDR_W +: ADDR_W];
        header_pkt_send       <= req_hdr[int'(sel)*HDR_W +: HDR_W];
      end
    end
  end

  // Strobes decode straight from the state register, so an asynchronous reset
  // drops them immediately.
  assign arbiter_gnt = (state == GRANT);
  assign busy        = (state != IDLE);

  always_comb begin
    req_ack = '0;
    if (state == GRANT)
      req_ack[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_input_port_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for input_port_arbiter: directed table of arbitration
// cases, multi-cycle corner-case sequences, and randomized transactions checked
// against a round-robin reference model.
// -----------------------------------------------------------------------------
module tb_input_port_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 1024;
  localparam int ADDR_W  = 10;
  localparam int HDR_W   = 9;
  localparam int TIMEOUT = 1023;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ*ADDR_W-1:0] req_dst;
  logic [NUM_REQ*HDR_W-1:0]  req_hdr;
  logic [NUM_REQ-1:0]        req_ack;
  logic                      arbiter_gnt;
  logic [DATA_W-1:0]         data_arbiter_send;
  logic [ADDR_W-1:0]         dst_addr_arbiter_send;
  logic [HDR_W-1:0]          header_pkt_send;
  logic                      ready_encap_dfx;
  logic                      empty;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;
  logic                      timeout_err;

  input_port_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .HDR_W(HDR_W), .TIMEOUT(TIMEOUT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_dst(req_dst),
    .req_hdr(req_hdr), .req_ack(req_ack), .arbiter_gnt(arbiter_gnt),
    .data_arbiter_send(data_arbiter_send),
    .dst_addr_arbiter_send(dst_addr_arbiter_send),
    .header_pkt_send(header_pkt_send), .ready_encap_dfx(ready_encap_dfx),
    .empty(empty), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int model_ptr = 0;

  typedef struct {
    logic [NUM_REQ-1:0] r;
    int                 exp_id;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got low bits %h expected low bits %h", nm, act[127:0], exp[127:0]);
    end
  endtask

  // Reference model: first requester at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r);
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (model_ptr + k) % NUM_REQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic fill_payloads();
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int w = 0; w < DATA_W / 32; w++)
        req_data[i*DATA_W + w*32 +: 32] = $urandom();
      req_dst[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(0, 1023));
      req_hdr[i*HDR_W +: HDR_W]   = HDR_W'($urandom_range(0, 511));
    end
  endtask

  // Checks the grant cycle: strobe, ack, id and payload of requester exp_id.
  task automatic chk_grant(input string nm, input int exp_id);
    logic [NUM_REQ-1:0] exp_ack;
    exp_ack = '0;
    exp_ack[exp_id] = 1'b1;
    chk({nm, " gnt"}, 64'(arbiter_gnt), 64'd1);
    chk({nm, " ack"}, 64'(req_ack), 64'(exp_ack));
    chk({nm, " id"}, 64'(grant_id), 64'(exp_id));
    chk_wide({nm, " data"}, data_arbiter_send, req_data[exp_id*DATA_W +: DATA_W]);
    chk({nm, " dst"}, 64'(dst_addr_arbiter_send), 64'(req_dst[exp_id*ADDR_W +: ADDR_W]));
    chk({nm, " hdr"}, 64'(header_pkt_send), 64'(req_hdr[exp_id*HDR_W +: HDR_W]));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk({nm, " return to idle"}, 64'(busy), 64'd0);
  endtask

  // Full transaction: request, grant next cycle, encapsulation pulse, drain.
  task automatic run_txn(input logic [NUM_REQ-1:0] r, input int exp_id, input string nm);
    req = r;
    tick();
    chk_grant(nm, exp_id);
    req = '0;
    tick();
    chk({nm, " gnt one cycle"}, {62'd0, arbiter_gnt, busy}, 64'd1);
    ready_encap_dfx = 1'b1;
    tick();
    ready_encap_dfx = 1'b0;
    wait_idle(nm);
    model_ptr = (exp_id + 1) % NUM_REQ;
  endtask

  initial begin
    logic [DATA_W-1:0] pat;
    int                bad;
    int                n;
    int                e;

    vecs[0] = '{4'b0100, 2};
    vecs[1] = '{4'b1111, 3};
    vecs[2] = '{4'b1111, 0};
    vecs[3] = '{4'b1111, 1};
    vecs[4] = '{4'b1111, 2};
    vecs[5] = '{4'b0011, 0};
    vecs[6] = '{4'b0011, 1};
    vecs[7] = '{4'b1001, 3};

    rst = 1'b1;
    req = '0;
    ready_encap_dfx = 1'b0;
    empty = 1'b1;
    req_data = '0;
    req_dst = '0;
    req_hdr = '0;
    #1;
    chk("reset gnt/ack/busy/err", {58'd0, arbiter_gnt, req_ack, busy, timeout_err}, 64'd0);
    chk("reset id/dst/hdr", {43'd0, grant_id, dst_addr_arbiter_send, header_pkt_send}, 64'd0);
    chk_wide("reset data", data_arbiter_send, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed single request with fixed payload, then the rest of the table.
    for (int v = 0; v < 8; v++) begin
      fill_payloads();
      if (v == 0) begin
        pat = {16{64'h1111222233339999}};
        req_data[2*DATA_W +: DATA_W] = pat;
        req_dst[2*ADDR_W +: ADDR_W]  = 10'hA;
        req_hdr[2*HDR_W +: HDR_W]    = 9'b100111101;
      end
      run_txn(vecs[v].r, vecs[v].exp_id, $sformatf("table%0d", v));
    end
    chk_wide("directed payload kept while idle", data_arbiter_send,
             req_data[3*DATA_W +: DATA_W]);

    // Hold-off: no second grant while waiting for encapsulation.
    fill_payloads();
    req = 4'b0011;
    e = rr_pick(4'b0011);
    tick();
    chk_grant("holdoff first", e);
    model_ptr = (e + 1) % NUM_REQ;
    empty = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (arbiter_gnt || !busy) bad++;
    end
    chk("holdoff no regrant", 64'(bad), 64'd0);
    ready_encap_dfx = 1'b1;
    tick();
    ready_encap_dfx = 1'b0;
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (arbiter_gnt || !busy) bad++;
    end
    chk("holdoff while not empty", 64'(bad), 64'd0);
    e = rr_pick(4'b0011);
    empty = 1'b1;
    n = 0;
    while (!arbiter_gnt && n < 10) begin
      tick();
      n++;
    end
    chk("holdoff cycles empty to gnt", 64'(n), 64'd2);
    chk_grant("holdoff second", e);
    model_ptr = (e + 1) % NUM_REQ;
    req = '0;
    tick();
    ready_encap_dfx = 1'b1;
    tick();
    ready_encap_dfx = 1'b0;
    wait_idle("holdoff");

    // Timeout: encapsulation never reported; next pending requester served.
    fill_payloads();
    req = 4'b0100;
    e = rr_pick(4'b0100);
    tick();
    chk_grant("timeout grant", e);
    model_ptr = (e + 1) % NUM_REQ;
    req = 4'b0001;
    n = 0;
    while (!timeout_err && n < TIMEOUT + 100) begin
      tick();
      n++;
    end
    chk("timeout cycles", 64'(n), 64'(TIMEOUT + 2));
    chk("timeout busy/gnt", {62'd0, busy, arbiter_gnt}, 64'd0);
    e = rr_pick(4'b0001);
    tick();
    chk_grant("after timeout", e);
    chk("timeout sticky", 64'(timeout_err), 64'd1);
    model_ptr = (e + 1) % NUM_REQ;
    req = '0;
    tick();
    ready_encap_dfx = 1'b1;
    tick();
    ready_encap_dfx = 1'b0;
    wait_idle("after timeout");

    // Reset during DRAIN after granting requester 1 (pointer then at 2).
    fill_payloads();
    req = 4'b0010;
    e = rr_pick(4'b0010);
    tick();
    chk_grant("pre-reset", e);
    req = '0;
    empty = 1'b0;
    tick();
    ready_encap_dfx = 1'b1;
    tick();
    ready_encap_dfx = 1'b0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("midreset gnt/ack/busy/err", {58'd0, arbiter_gnt, req_ack, busy, timeout_err}, 64'd0);
    chk("midreset id/dst/hdr", {43'd0, grant_id, dst_addr_arbiter_send, header_pkt_send}, 64'd0);
    chk_wide("midreset data", data_arbiter_send, '0);
    @(negedge clk);
    rst = 1'b0;
    empty = 1'b1;
    tick();
    model_ptr = 0;
    fill_payloads();
    run_txn(4'b1010, 1, "after reset ptr0");
    fill_payloads();
    run_txn(4'b1000, 3, "after reset single");

    // Ready level already high: only a fresh rising edge ends WAIT_RDY.
    fill_payloads();
    ready_encap_dfx = 1'b1;
    tick();
    req = 4'b0100;
    e = rr_pick(4'b0100);
    tick();
    chk_grant("level ready", e);
    model_ptr = (e + 1) % NUM_REQ;
    req = '0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!busy) bad++;
    end
    chk("level ready held busy", 64'(bad), 64'd0);
    ready_encap_dfx = 1'b0;
    tick();
    ready_encap_dfx = 1'b1;
    wait_idle("level ready re-edge");
    ready_encap_dfx = 1'b0;
    tick();

    // Randomized transactions against the reference model.
    for (int t = 0; t < 40; t++) begin
      logic [NUM_REQ-1:0] r;
      r = NUM_REQ'($urandom_range(1, 15));
      fill_payloads();
      run_txn(r, rr_pick(r), $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
